// File: rtl/sap_cpu.sv
// SAP-style accumulator CPU with its own program RAM and a program-load port.
// Variable-length instructions run T0..T4; the load port holds the core and restarts it at address 0.
module sap_cpu #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_mode,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output logic [AW-1:0] pc
);

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_OUT = 4'he, OP_HLT = 4'hf;
  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4;

  typedef enum logic {RUN, HALT} state_t;

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] mar;
  logic [DW-1:0] ir, a, b;
  logic          cf, zf;
  logic [2:0]    step, step_nxt;
  state_t        state, state_nxt;

  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW-1:0] rd;
  logic          sub;
  logic [DW:0]   alu;

  assign opcode  = ir[DW-1:DW-4];
  assign operand = ir[AW-1:0];
  assign rd      = mem[mar];
  assign sub     = (opcode == OP_SUB);
  // SUB is A + ~B + 1, so CF means "no borrow"
  assign alu     = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{DW{1'b0}}, sub};
  assign halted  = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      step  <= T0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    if (prog_mode) begin
      state_nxt = RUN;
      step_nxt  = T0;
    end else if (state == RUN) begin
      step_nxt = step + 3'd1;
      case (step)
        T2: begin
          case (opcode)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: step_nxt = T3;
            OP_HLT: begin
              state_nxt = HALT;
              step_nxt  = T0;
            end
            default: step_nxt = T0;
          endcase
        end
        T3: if (opcode != OP_ADD && opcode != OP_SUB) step_nxt = T0;
        T4: step_nxt = T0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (prog_mode) begin
      pc        <= '0;
      mar       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == RUN) begin
        case (step)
          T0: mar <= pc;
          T1: begin
            ir <= rd;
            pc <= pc + 1'b1;
          end
          T2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
              OP_LDI: a <= {4'b0, ir[DW-5:0]};
              OP_JMP: pc <= operand;
              OP_JC:  if (cf) pc <= operand;
              OP_JZ:  if (zf) pc <= operand;
              OP_OUT: begin
                out_data  <= a;
                out_valid <= 1'b1;
              end
              default: ;
            endcase
          end
          T3: begin
            if (opcode == OP_LDA) a <= rd;
            if (opcode == OP_ADD || opcode == OP_SUB) b <= rd;
          end
          T4: begin
            a  <= alu[DW-1:0];
            cf <= alu[DW];
            zf <= (alu[DW-1:0] == '0);
          end
          default: ;
        endcase
      end
    end
  end

  // RAM is deliberately outside the reset domain so a loaded program survives rst
  always_ff @(posedge clk) begin
    if (prog_mode) begin
      if (prog_we) mem[prog_addr] <= prog_data;
    end else if (state == RUN && step == T3 && opcode == OP_STA) begin
      mem[mar] <= a;
    end
  end

endmodule
